// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if -- start/operand/result bundle between control_unit and
// the multiply/divide sequencer.
//   MultCtrl, DivCtrl : one-cycle start pulses (master -> slave)
//   A, B              : operands, latched by the sequencer at start
//   HI, LO            : result pair owned by the sequencer
//   multStop, DivStop : one-cycle completion pulses
//   DivZero           : one-cycle divide-by-zero pulse
//   busy              : operation in progress
interface mult_div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             MultCtrl;
  logic             DivCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             multStop;
  logic             DivStop;
  logic             DivZero;
  logic             busy;

  modport master (
    output MultCtrl, DivCtrl, A, B,
    input  HI, LO, multStop, DivStop, DivZero, busy
  );

  modport slave (
    input  MultCtrl, DivCtrl, A, B,
    output HI, LO, multStop, DivStop, DivZero, busy
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl -- iterative signed multiply/divide sequencer owning HI/LO.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : mult_div_ctrl_if.slave (start pulses, operands, HI/LO, status)
// Multiply is radix-2 Booth, divide is restoring division on magnitudes with
// a sign fix-up; both take WIDTH step cycles plus one fix-up cycle.
// Optional build macro MULTDIV_EARLY_EXIT_EN: a divide whose |A| < |B|
// skips the step cycles and completes at the first edge after start.
module mult_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);
  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE, DZ} state_e;

  state_e             state_q;
  logic               is_div_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand, or divisor magnitude
  logic [2*WIDTH:0]   acc_q;    // mult: {hi, lo, q-1}; div: {rem(W+1), quo(W)}
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   HI_q;
  logic [WIDTH-1:0]   LO_q;
  logic               multStop_q;
  logic               DivStop_q;
  logic               DivZero_q;
  logic               busy_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               early_exit;
  logic [WIDTH:0]     booth_hi;
  logic [WIDTH:0]     booth_m;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     dvsr;
  logic               ge;
  logic [2*WIDTH:0]   div_next;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    mag_a = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    mag_b = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
`ifdef MULTDIV_EARLY_EXIT_EN
    early_exit = (mag_a < mag_b);
`else
    early_exit = 1'b0;
`endif
  end

  // Booth step: the add/sub is done one bit wider than hi so that
  // subtracting the most negative multiplicand cannot overflow; the extra
  // sign bit becomes the MSB after the arithmetic shift, keeping the
  // accumulator at 2W+1 bits.
  always_comb begin
    booth_hi = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    booth_m  = {opnd_q[WIDTH-1], opnd_q};
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_hi + booth_m;
      2'b10:   booth_sum = booth_hi - booth_m;
      default: booth_sum = booth_hi;
    endcase
    booth_next = {booth_sum, acc_q[WIDTH:1]};
  end

  // Restoring step: shift {rem, quo} left one bit, subtract the divisor
  // from the remainder when it fits, and shift the outcome bit into quo.
  always_comb begin
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    dvsr     = {1'b0, opnd_q};
    ge       = (rem_sh >= dvsr);
    div_next = {(ge ? (rem_sh - dvsr) : rem_sh), acc_q[WIDTH-2:0], ge};
  end

  // Sign fix-up: quotient negated on differing signs (the -2^(W-1)/-1 case
  // wraps naturally), remainder follows the dividend's sign.
  always_comb begin
    fix_lo = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                   : acc_q[WIDTH-1:0];
    fix_hi = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                      : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      HI_q       <= '0;
      LO_q       <= '0;
      multStop_q <= 1'b0;
      DivStop_q  <= 1'b0;
      DivZero_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MultCtrl) begin
            opnd_q   <= bus.A;
            acc_q    <= {{WIDTH{1'b0}}, bus.B, 1'b0};
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= MULT;
          end else if (bus.DivCtrl) begin
            busy_q <= 1'b1;
            if (bus.B == '0) begin
              DivZero_q <= 1'b1;
              state_q   <= DZ;
            end else begin
              opnd_q   <= mag_b;
              sign_a_q <= bus.A[WIDTH-1];
              sign_b_q <= bus.B[WIDTH-1];
              cnt_q    <= '0;
              is_div_q <= 1'b1;
              if (early_exit) begin
                // Quotient 0, remainder |A| straight into the fix-up.
                acc_q   <= {1'b0, mag_a, {WIDTH{1'b0}}};
                state_q <= FIX;
              end else begin
                acc_q   <= {{(WIDTH+1){1'b0}}, mag_a};
                state_q <= DIV;
              end
            end
          end
        end
        MULT: begin
          acc_q <= booth_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            HI_q      <= fix_hi;
            LO_q      <= fix_lo;
            DivStop_q <= 1'b1;
          end else begin
            HI_q       <= acc_q[2*WIDTH:WIDTH+1];
            LO_q       <= acc_q[WIDTH:1];
            multStop_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          multStop_q <= 1'b0;
          DivStop_q  <= 1'b0;
          state_q    <= IDLE;
        end
        DZ: begin
          DivZero_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HI       = HI_q;
  assign bus.LO       = LO_q;
  assign bus.multStop = multStop_q;
  assign bus.DivStop  = DivStop_q;
  assign bus.DivZero  = DivZero_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl -- directed and randomized bench for mult_div_ctrl.
// Expected results come from plain 64-bit signed arithmetic; latency and
// pulse behaviour come from the documented edge counts.
module tb_mult_div_ctrl;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic void model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint p, q, r;
    if (!is_div) begin
      p  = sx(a) * sx(b);
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sx(a) / sx(b);
      r  = sx(a) % sx(b);
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  function automatic int unsigned exp_latency(input bit is_div, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint ma, mb;
    ma = sx(a) < 0 ? -sx(a) : sx(a);
    mb = sx(b) < 0 ? -sx(b) : sx(b);
`ifdef MULTDIV_EARLY_EXIT_EN
    if (is_div && ma < mb) return 1;
`else
    if (is_div && ma < mb) return W + 1;
`endif
    return W + 1;
  endfunction

  function automatic logic stop_of(input bit is_div);
    return is_div ? bus.DivStop : bus.multStop;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = W'($urandom_range(0, 20));
      4:       v = -W'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Launch one operation (start sampled at the next rising edge, E0) and
  // follow it through to the stop pulse or the divide-by-zero pulse.
  task automatic run_op(input bit is_div, input bit both, input bit poke,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n;
    bit eff_div;
    logic [W-1:0] eh, el;
    eff_div = is_div && !both;
    @(negedge clk);
    bus.MultCtrl = !is_div || both;
    bus.DivCtrl  = is_div || both;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    if (eff_div && b == '0) begin
      chk("dz_flag", bus.DivZero, 1);
      chk("dz_busy", bus.busy, 1);
      chk("dz_nostop", bus.DivStop, 0);
      @(negedge clk);
      chk("dz_clear", bus.DivZero, 0);
      chk("dz_busy_clr", bus.busy, 0);
      chk("dz_hi_hold", bus.HI, hi_m);
      chk("dz_lo_hold", bus.LO, lo_m);
      return;
    end
    model(eff_div, a, b, eh, el);
    chk("busy_run", bus.busy, 1);
    n = 0;
    while (!stop_of(eff_div) && n < 60) begin
      if (poke && n == 4) begin
        bus.MultCtrl = 1'b1;
        bus.A = 32'd1;
        bus.B = 32'd1;
      end
      @(negedge clk);
      bus.MultCtrl = 1'b0;
      n++;
    end
    chk("latency", n, exp_latency(eff_div, a, b));
    chk("hi", bus.HI, eh);
    chk("lo", bus.LO, el);
    chk("other_stop", eff_div ? bus.multStop : bus.DivStop, 0);
    chk("no_dz", bus.DivZero, 0);
    chk("busy_done", bus.busy, 0);
    hi_m = eh;
    lo_m = el;
    @(negedge clk);
    chk("stop_pulse", stop_of(eff_div), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned seen;
    reset = 1'b1;
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mstop", bus.multStop, 0);
    chk("rst_dstop", bus.DivStop, 0);
    chk("rst_dz", bus.DivZero, 0);
    reset = 1'b0;

    // Preload HI/LO, then reset mid-multiply just before E10.
    run_op(0, 0, 0, 32'h0001_2345, 32'hFFFF_F777);
    @(negedge clk);
    bus.MultCtrl = 1'b1;
    bus.A = 32'd1234;
    bus.B = 32'd5678;
    @(negedge clk);
    bus.MultCtrl = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.HI, 0);
    chk("midrst_lo", bus.LO, 0);
    chk("midrst_mstop", bus.multStop, 0);
    hi_m = '0;
    lo_m = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.multStop) seen++;
    end
    chk("midrst_nostop", seen, 0);

    run_op(0, 0, 0, 32'd3, 32'd5);
    run_op(0, 0, 0, 32'h8000_0000, 32'h8000_0000);
    run_op(0, 0, 0, -32'd7, 32'd6);
    run_op(1, 0, 0, -32'd7, 32'd2);
    run_op(1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1, 0, 0, 32'd55, 32'd0);
    run_op(1, 1, 1, 32'd4, 32'd2);
    run_op(0, 0, 0, 32'd9, -32'd9);
    run_op(1, 0, 0, 32'd3, 32'd10);
    run_op(1, 0, 0, -32'd3, 32'd10);

    for (int i = 0; i < 40; i++) begin
      run_op(bit'($urandom_range(0, 1)), 1'b0, 1'b0, pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
